// File: rtl/video_frame_checker.sv
// -----------------------------------------------------------------------------
// video_frame_checker
//
// Per-frame monitor for a display output stream. For every frame delimited by
// vsync rising edges it measures the active geometry (first line length, line
// count), accumulates a checksum of R+G+B over all valid pixels and flags any
// line whose length differs from WIDTH or a line count differing from HEIGHT.
// Results are published together with a one-cycle frame_done pulse and hold
// until the next publish or reset.
//
// Ports
//   disp_clk    in   display pixel clock
//   rst_disp    in   synchronous active-high reset
//   vsync       in   vertical sync, active level VS_POL
//   hsync       in   horizontal sync, active level HS_POL
//   de          in   data enable, active-high
//   rgb         in   pixel {R,G,B}, CDW bits per channel
//   frame_done  out  one-cycle pulse when a frame's results are published
//   frame_cnt   out  completed-frame count (wraps)
//   meas_width  out  length of the first line of the last frame
//   meas_height out  line count of the last frame
//   frame_sum   out  sum of R+G+B over valid pixels of the last frame, mod 2^32
//   err_width   out  last frame had a line length != WIDTH
//   err_height  out  last frame line count != HEIGHT
//   frame_ok    out  last frame had no error
//   err_sticky  out  OR of all errors since reset
// -----------------------------------------------------------------------------
module video_frame_checker #(
    parameter int WIDTH   = 1024,
    parameter int HEIGHT  = 768,
    parameter int CDW     = 10,
    parameter int VS_POL  = 1,
    parameter int HS_POL  = 1,
    parameter int QUAL_HS = 1
) (
    input  logic             disp_clk,
    input  logic             rst_disp,
    input  logic             vsync,
    input  logic             hsync,
    input  logic             de,
    input  logic [3*CDW-1:0] rgb,
    output logic             frame_done,
    output logic [15:0]      frame_cnt,
    output logic [15:0]      meas_width,
    output logic [15:0]      meas_height,
    output logic [31:0]      frame_sum,
    output logic             err_width,
    output logic             err_height,
    output logic             frame_ok,
    output logic             err_sticky
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t state, state_nxt;

    // Registered, polarity-normalised inputs (1 = active).
    logic             vs_r, vs_d, hs_r, de_r;
    logic [3*CDW-1:0] rgb_r;

    // Per-frame accumulators.
    logic [15:0] run_len, lines, first_len;
    logic        werr;
    logic [31:0] acc_sum;
    logic        pix_v_d;

    // FSM control strobes.
    logic acc_en, acc_clr, publish;

    // NOTE: sequential state is always written with non-blocking assignments so
    // every register samples the pre-edge value of every other register.
    always_ff @(posedge disp_clk) begin
        if (rst_disp) begin
            vs_r  <= 1'b0;
            vs_d  <= 1'b0;
            hs_r  <= 1'b0;
            de_r  <= 1'b0;
            rgb_r <= '0;
        end else begin
            vs_r  <= (VS_POL != 0) ? vsync : ~vsync;
            vs_d  <= vs_r;
            hs_r  <= (HS_POL != 0) ? hsync : ~hsync;
            de_r  <= de;
            rgb_r <= rgb;
        end
    end

    logic            vs_edge, pix_v, close_line, herr_nxt, werr_nxt;
    logic [CDW+1:0]  pix_sum;
    logic [15:0]     run_inc, lines_inc, first_len_nxt;
    logic [31:0]     sum_nxt;

    assign vs_edge = vs_r & ~vs_d;
    assign pix_v   = de_r & ((QUAL_HS != 0) ? hs_r : 1'b1);
    assign pix_sum = (CDW+2)'(rgb_r[3*CDW-1:2*CDW]) + (CDW+2)'(rgb_r[2*CDW-1:CDW])
                   + (CDW+2)'(rgb_r[CDW-1:0]);

    // Line length including the current pixel, saturating.
    assign run_inc = (pix_v && run_len != 16'hFFFF) ? run_len + 16'd1 : run_len;

    // A line closes on the falling edge of pix_v, or on a frame edge while a
    // line is open; in the latter case the coincident pixel belongs to it.
    assign close_line    = vs_edge ? (run_inc != 16'd0) : (pix_v_d & ~pix_v);
    assign lines_inc     = (close_line && lines != 16'hFFFF) ? lines + 16'd1 : lines;
    assign first_len_nxt = (close_line && lines == 16'd0) ? run_inc : first_len;
    assign werr_nxt      = werr | (close_line && run_inc != 16'(WIDTH));
    assign herr_nxt      = (lines_inc != 16'(HEIGHT));
    assign sum_nxt       = pix_v ? acc_sum + 32'(pix_sum) : acc_sum;

    // FSM: state register.
    always_ff @(posedge disp_clk) begin
        if (rst_disp) state <= IDLE;
        else          state <= state_nxt;
    end

    // FSM: next state. Once a frame edge has been seen the checker stays in
    // ACTIVE; only reset returns it to IDLE.
    always_comb begin
        state_nxt = state;
        if (state == IDLE && vs_edge) state_nxt = ACTIVE;
    end

    // FSM: outputs.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        acc_en  = 1'b0;
        acc_clr = 1'b0;
        publish = 1'b0;
        case (state)
            IDLE:   acc_clr = vs_edge;
            ACTIVE: begin
                acc_en  = 1'b1;
                acc_clr = vs_edge;
                publish = vs_edge;
            end
            default: ;
        endcase
    end

    // Accumulators and published results.
    always_ff @(posedge disp_clk) begin
        if (rst_disp) begin
            run_len     <= '0;
            lines       <= '0;
            first_len   <= '0;
            werr        <= 1'b0;
            acc_sum     <= '0;
            pix_v_d     <= 1'b0;
            frame_done  <= 1'b0;
            frame_cnt   <= '0;
            meas_width  <= '0;
            meas_height <= '0;
            frame_sum   <= '0;
            err_width   <= 1'b0;
            err_height  <= 1'b0;
            frame_ok    <= 1'b0;
            err_sticky  <= 1'b0;
        end else begin
            frame_done <= publish;

            // Clearing pix_v_d on a frame edge stops the pixel already
            // credited to the old frame from closing a phantom line.
            if (acc_clr) begin
                run_len   <= '0;
                lines     <= '0;
                first_len <= '0;
                werr      <= 1'b0;
                acc_sum   <= '0;
                pix_v_d   <= 1'b0;
            end else if (acc_en) begin
                run_len   <= close_line ? 16'd0 : run_inc;
                lines     <= lines_inc;
                first_len <= first_len_nxt;
                werr      <= werr_nxt;
                acc_sum   <= sum_nxt;
                pix_v_d   <= pix_v;
            end

            if (publish) begin
                meas_width  <= first_len_nxt;
                meas_height <= lines_inc;
                frame_sum   <= sum_nxt;
                err_width   <= werr_nxt;
                err_height  <= herr_nxt;
                frame_ok    <= ~(werr_nxt | herr_nxt);
                err_sticky  <= err_sticky | werr_nxt | herr_nxt;
                frame_cnt   <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_video_frame_checker.sv
// -----------------------------------------------------------------------------
// tb_video_frame_checker
//
// Directed bench for video_frame_checker with a 4x3 geometry. Two instances
// share one stimulus: u_q qualifies pixels with hsync, u_n uses de alone.
// -----------------------------------------------------------------------------
module tb_video_frame_checker;

    localparam int CDW = 10;
    localparam logic [3*CDW-1:0] P1   = {10'd1, 10'd2, 10'd3};          // 6 per pixel
    localparam logic [3*CDW-1:0] PMAX = {10'd1023, 10'd1023, 10'd1023}; // 3069 per pixel

    logic             disp_clk = 1'b0;
    logic             rst_disp, vsync, hsync, de;
    logic [3*CDW-1:0] rgb;

    logic        q_frame_done, q_err_width, q_err_height, q_frame_ok, q_err_sticky;
    logic [15:0] q_frame_cnt, q_meas_width, q_meas_height;
    logic [31:0] q_frame_sum;
    logic        n_frame_done, n_err_width, n_err_height, n_frame_ok, n_err_sticky;
    logic [15:0] n_frame_cnt, n_meas_width, n_meas_height;
    logic [31:0] n_frame_sum;

    video_frame_checker #(
        .WIDTH(4), .HEIGHT(3), .CDW(CDW), .VS_POL(1), .HS_POL(1), .QUAL_HS(1)
    ) u_q (
        .disp_clk(disp_clk), .rst_disp(rst_disp), .vsync(vsync), .hsync(hsync),
        .de(de), .rgb(rgb), .frame_done(q_frame_done), .frame_cnt(q_frame_cnt),
        .meas_width(q_meas_width), .meas_height(q_meas_height),
        .frame_sum(q_frame_sum), .err_width(q_err_width), .err_height(q_err_height),
        .frame_ok(q_frame_ok), .err_sticky(q_err_sticky)
    );

    video_frame_checker #(
        .WIDTH(4), .HEIGHT(3), .CDW(CDW), .VS_POL(1), .HS_POL(1), .QUAL_HS(0)
    ) u_n (
        .disp_clk(disp_clk), .rst_disp(rst_disp), .vsync(vsync), .hsync(hsync),
        .de(de), .rgb(rgb), .frame_done(n_frame_done), .frame_cnt(n_frame_cnt),
        .meas_width(n_meas_width), .meas_height(n_meas_height),
        .frame_sum(n_frame_sum), .err_width(n_err_width), .err_height(n_err_height),
        .frame_ok(n_frame_ok), .err_sticky(n_err_sticky)
    );

    always #5 disp_clk = ~disp_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int done_q   = 0;
    int done_n   = 0;

    // Count frame_done pulses away from the active edge.
    always @(negedge disp_clk) begin
        if (q_frame_done === 1'b1) done_q++;
        if (n_frame_done === 1'b1) done_n++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input bit sel,
                           input logic [15:0] cnt, input logic [15:0] w,
                           input logic [15:0] h, input logic [31:0] sum,
                           input logic ew, input logic eh, input logic ok,
                           input logic st);
        if (sel == 1'b0) begin
            check({tag, ".cnt"},    q_frame_cnt,   cnt);
            check({tag, ".width"},  q_meas_width,  w);
            check({tag, ".height"}, q_meas_height, h);
            check({tag, ".sum"},    q_frame_sum,   sum);
            check({tag, ".ew"},     q_err_width,   ew);
            check({tag, ".eh"},     q_err_height,  eh);
            check({tag, ".ok"},     q_frame_ok,    ok);
            check({tag, ".sticky"}, q_err_sticky,  st);
        end else begin
            check({tag, ".cnt"},    n_frame_cnt,   cnt);
            check({tag, ".width"},  n_meas_width,  w);
            check({tag, ".height"}, n_meas_height, h);
            check({tag, ".sum"},    n_frame_sum,   sum);
            check({tag, ".ew"},     n_err_width,   ew);
            check({tag, ".eh"},     n_err_height,  eh);
            check({tag, ".ok"},     n_frame_ok,    ok);
            check({tag, ".sticky"}, n_err_sticky,  st);
        end
    endtask

    // One clock: inputs set before the call are sampled at this edge.
    task automatic cyc();
        @(posedge disp_clk);
        #1;
    endtask

    task automatic idle(input int n);
        de = 1'b0; hsync = 1'b0; vsync = 1'b0;
        repeat (n) cyc();
    endtask

    // n pixels with per-pixel hsync from hmask, then two blank cycles.
    task automatic line(input int n, input logic [3:0] hmask, input logic [3*CDW-1:0] pix);
        for (int i = 0; i < n; i++) begin
            de = 1'b1; hsync = hmask[i]; rgb = pix;
            cyc();
        end
        de = 1'b0; hsync = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic good_frame(input logic [3*CDW-1:0] pix);
        line(4, 4'hF, pix);
        line(4, 4'hF, pix);
        line(4, 4'hF, pix);
    endtask

    // vsync active for 'hold' cycles; checks frame_done exactly one edge after
    // the sampling edge and low again once vsync drops.
    task automatic vs_edge_step(input string tag, input int hold, input logic exp_done);
        vsync = 1'b1; de = 1'b0; hsync = 1'b0;
        cyc();
        if (hold < 2) vsync = 1'b0;
        cyc();
        check({tag, ".done_q"}, q_frame_done, exp_done);
        check({tag, ".done_n"}, n_frame_done, exp_done);
        for (int i = 2; i < hold; i++) cyc();
        vsync = 1'b0;
        cyc();
        check({tag, ".done_q_low"}, q_frame_done, 1'b0);
    endtask

    initial begin
        vsync = 1'b0; hsync = 1'b0; de = 1'b0; rgb = '0; rst_disp = 1'b1;
        cyc();
        cyc();
        chk_res("reset", 1'b0, 16'd0, 16'd0, 16'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset.done", q_frame_done, 1'b0);
        rst_disp = 1'b0;

        // Valid pixels before the first frame edge are ignored.
        line(4, 4'hF, P1);
        vs_edge_step("edge1", 1, 1'b0);
        check("edge1.cnt", q_frame_cnt, 16'd0);

        // Good frames; the second frame edge uses a long vsync (one edge only).
        good_frame(P1);
        vs_edge_step("f1", 1, 1'b1);
        chk_res("f1", 1'b0, 16'd1, 16'd4, 16'd3, 32'd72, 1'b0, 1'b0, 1'b1, 1'b0);
        good_frame(P1);
        vs_edge_step("f2", 3, 1'b1);
        chk_res("f2", 1'b0, 16'd2, 16'd4, 16'd3, 32'd72, 1'b0, 1'b0, 1'b1, 1'b0);

        // Short middle line.
        line(4, 4'hF, P1);
        line(3, 4'hF, P1);
        line(4, 4'hF, P1);
        vs_edge_step("f3", 1, 1'b1);
        chk_res("f3", 1'b0, 16'd3, 16'd4, 16'd3, 32'd66, 1'b1, 1'b0, 1'b0, 1'b1);

        // Good frame at full-scale pixel values; sticky error remains.
        good_frame(PMAX);
        vs_edge_step("f4", 1, 1'b1);
        chk_res("f4", 1'b0, 16'd4, 16'd4, 16'd3, 32'd36828, 1'b0, 1'b0, 1'b1, 1'b1);

        // Only two lines.
        line(4, 4'hF, P1);
        line(4, 4'hF, P1);
        vs_edge_step("f5", 1, 1'b1);
        chk_res("f5", 1'b0, 16'd5, 16'd4, 16'd2, 32'd48, 1'b0, 1'b1, 1'b0, 1'b1);

        // hsync inactive on the last two of four de pixels of the first line.
        line(4, 4'b0011, P1);
        line(4, 4'hF, P1);
        line(4, 4'hF, P1);
        vs_edge_step("f6", 1, 1'b1);
        chk_res("f6q", 1'b0, 16'd6, 16'd2, 16'd3, 32'd60, 1'b1, 1'b0, 1'b0, 1'b1);
        chk_res("f6n", 1'b1, 16'd6, 16'd4, 16'd3, 32'd72, 1'b0, 1'b0, 1'b1, 1'b1);

        // Frame edge coincides with the third pixel of line 3.
        line(4, 4'hF, P1);
        line(4, 4'hF, P1);
        de = 1'b1; hsync = 1'b1; rgb = P1;
        cyc();
        cyc();
        vsync = 1'b1;
        cyc();
        vsync = 1'b0; de = 1'b0; hsync = 1'b0;
        cyc();
        check("f7.done", q_frame_done, 1'b1);
        chk_res("f7", 1'b0, 16'd7, 16'd4, 16'd3, 32'd66, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc();
        check("f7.done_low", q_frame_done, 1'b0);

        // Reset mid-frame, then the next edge only starts a frame.
        line(4, 4'hF, P1);
        de = 1'b1; hsync = 1'b1;
        cyc();
        cyc();
        rst_disp = 1'b1; de = 1'b0; hsync = 1'b0;
        cyc();
        chk_res("midrst", 1'b0, 16'd0, 16'd0, 16'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("midrst.n_cnt", n_frame_cnt, 16'd0);
        rst_disp = 1'b0;
        idle(2);
        vs_edge_step("edge9", 1, 1'b0);
        check("edge9.cnt", q_frame_cnt, 16'd0);
        good_frame(P1);
        vs_edge_step("f8", 1, 1'b1);
        chk_res("f8", 1'b0, 16'd1, 16'd4, 16'd3, 32'd72, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);

        check("total_done_q", done_q, 32'd8);
        check("total_done_n", done_n, 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
